matrix_transpose_stream: RTL and testbench

Parametrised DIMxDIM matrix transpose engine, successor to the fixed 4x4 transpose unit.
- Accepts a matrix one row per handshake and returns it one column per handshake, using valid/ready flow control instead of a shared tristate bus.
- Holds one matrix in a register array.
- Selectable mode: transpose or pass-through.
- Sits between the matrix ALU operand loader and the result writer.

---
 rtl/mtx_pkg.sv | 19 +
 rtl/mtx_col_select.sv | 26 ++
 rtl/matrix_transpose_stream.sv | 135 +++++++++++++
 tb/tb_matrix_transpose_stream.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mtx_pkg.sv
// Shared types and sizing helpers for the matrix transpose/stream datapath.
package mtx_pkg;

  localparam int MTX_DATASIZE = 16;

  typedef logic [MTX_DATASIZE-1:0] elem_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Row/column counter width; a 1x1 matrix still needs a 1-bit counter.
  function automatic int cnt_width(input int dim);
    return (dim <= 1) ? 1 : $clog2(dim);
  endfunction

endpackage

// File: rtl/mtx_col_select.sv
// Combinational DIMxDIM storage to one beat: row idx_i (pass-through) or column idx_i (transpose).
// No latency, no state; the caller holds idx_i stable to keep the beat stable.
module mtx_col_select
  import mtx_pkg::*;
#(
  parameter  int DIM      = 4,
  parameter  int DATASIZE = MTX_DATASIZE,
  localparam int ROW_W    = DIM * DATASIZE,
  localparam int CW       = cnt_width(DIM)
) (
  input  logic [DIM-1:0][ROW_W-1:0] mem_i,
  input  logic [CW-1:0]             idx_i,
  input  logic                      transpose_i,
  output logic [ROW_W-1:0]          row_o
);

  always_comb begin
    row_o = mem_i[idx_i];
    if (transpose_i) begin
      for (int i = 0; i < DIM; i++) begin
        row_o[i*DATASIZE +: DATASIZE] = mem_i[i][idx_i*DATASIZE +: DATASIZE];
      end
    end
  end

endmodule

// File: rtl/matrix_transpose_stream.sv
// Single-buffer DIMxDIM transpose: rows in, columns (or rows) out, valid/ready both sides; drain starts one cycle after the last row.
// Optional MTX_ABORT_EN adds an abort input that discards a partially loaded or draining matrix.
module matrix_transpose_stream
  import mtx_pkg::*;
#(
  parameter  int DIM      = 4,
  parameter  int DATASIZE = MTX_DATASIZE,
  localparam int ROW_W    = DIM * DATASIZE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ROW_W-1:0] in_row,
  input  logic             mode,
`ifdef MTX_ABORT_EN
  input  logic             abort,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ROW_W-1:0] out_row,
  output logic             busy,
  output logic             done
);

  localparam int            CW   = cnt_width(DIM);
  localparam logic [CW-1:0] LAST = CW'(DIM - 1);

  state_e                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     mode_q, mode_d;
  logic                     done_q, done_d;
  logic                     wr_en;
  logic [DIM-1:0][ROW_W-1:0] mem_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    done_d    = 1'b0;
    wr_en     = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_en  = 1'b1;
          mode_d = mode;
          if (DIM == 1) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end else begin
            state_d = LOAD;
            cnt_d   = CW'(1);
          end
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          wr_en = 1'b1;
          if (cnt_q == LAST) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          if (cnt_q == LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
`ifdef MTX_ABORT_EN
    // Abort overrides any same-cycle handshake: the beat is dropped, no done.
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
      wr_en   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  // Matrix storage carries no reset; contents are only meaningful once loaded.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[cnt_q] <= in_row;
    end
  end

  assign done = done_q;

  mtx_col_select #(
    .DIM      (DIM),
    .DATASIZE (DATASIZE)
  ) u_col_select (
    .mem_i       (mem_q),
    .idx_i       (cnt_q),
    .transpose_i (mode_q),
    .row_o       (out_row)
  );

endmodule

// File: tb/tb_matrix_transpose_stream.sv
// Directed bench: 4x4 transpose/pass-through, back-pressure, reset mid-op, 1x1 matrix, optional abort.
module tb_matrix_transpose_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, mode, out_valid, out_ready, busy, done;
  logic [63:0] in_row, out_row;
  logic        in_valid1, in_ready1, mode1, out_valid1, out_ready1, busy1, done1;
  logic [15:0] in_row1, out_row1;
  logic        abort, abort1;

  int checks = 0;
  int errors = 0;

  logic [63:0] ROWS [4];
  logic [63:0] COLS [4];

  always #5 clk = ~clk;

  matrix_transpose_stream #(.DIM(4), .DATASIZE(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .mode      (mode),
`ifdef MTX_ABORT_EN
    .abort     (abort),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .busy      (busy),
    .done      (done)
  );

  matrix_transpose_stream #(.DIM(1), .DATASIZE(16)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_row    (in_row1),
    .mode      (mode1),
`ifdef MTX_ABORT_EN
    .abort     (abort1),
`endif
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .out_row   (out_row1),
    .busy      (busy1),
    .done      (done1)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Rows are driven right after the edge; the handshake happens on the next edge.
  task automatic load_matrix(input logic m_first, input logic m_rest);
    for (int r = 0; r < 4; r++) begin
      in_row   = ROWS[r];
      mode     = (r == 0) ? m_first : m_rest;
      in_valid = 1'b1;
      check_val("in_ready_load", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    mode     = 1'b0;
    check_val("out_valid_latency", out_valid, 1);
  endtask

  task automatic drain_matrix(input bit transpose, input int stall_beat, input string tag);
    logic [63:0] exp;
    for (int b = 0; b < 4; b++) begin
      exp = transpose ? COLS[b] : ROWS[b];
      if (b == stall_beat) begin
        out_ready = 1'b0;
        repeat (5) begin
          @(posedge clk); #1;
          check_val("bp_out_row", out_row, exp);
          check_val("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
      end
      check_val("beat_valid", out_valid, 1);
      check_val(tag, out_row, exp);
      check_val("no_early_done", done, 0);
      @(posedge clk); #1;
    end
    check_val("done_pulse", done, 1);
    check_val("in_ready_with_done", in_ready, 1);
    check_val("busy_idle", busy, 0);
    check_val("out_valid_idle", out_valid, 0);
    @(posedge clk); #1;
    check_val("done_one_cycle", done, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ROWS[0] = 64'h0004_0003_0002_0001;
    ROWS[1] = 64'h0008_0007_0006_0005;
    ROWS[2] = 64'h000C_000B_000A_0009;
    ROWS[3] = 64'h0010_000F_000E_000D;
    COLS[0] = 64'h000D_0009_0005_0001;
    COLS[1] = 64'h000E_000A_0006_0002;
    COLS[2] = 64'h000F_000B_0007_0003;
    COLS[3] = 64'h0010_000C_0008_0004;

    reset = 1'b1; in_valid = 1'b0; in_row = '0; mode = 1'b0; out_ready = 1'b1; abort = 1'b0;
    in_valid1 = 1'b0; in_row1 = '0; mode1 = 1'b0; out_ready1 = 1'b0; abort1 = 1'b0;
    #12;
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    load_matrix(1'b1, 1'b1);
    drain_matrix(1'b1, -1, "transpose_beat");

    // mode is taken from the first row only; later toggles must be ignored
    load_matrix(1'b0, 1'b1);
    drain_matrix(1'b0, -1, "passthru_beat");

    load_matrix(1'b1, 1'b1);
    drain_matrix(1'b1, 2, "bp_transpose_beat");

    for (int r = 0; r < 2; r++) begin
      in_row = ROWS[r]; mode = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check_val("partial_busy", busy, 1);
    reset = 1'b1; #2;
    check_val("rst_mid_out_valid", out_valid, 0);
    check_val("rst_mid_busy", busy, 0);
    check_val("rst_mid_in_ready", in_ready, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    check_val("rst_mid_no_done", done, 0);
    load_matrix(1'b1, 1'b1);
    drain_matrix(1'b1, -1, "after_rst_beat");

    load_matrix(1'b1, 1'b1);
    reset = 1'b1; #1;
    check_val("rst_drain_out_valid", out_valid, 0);
    check_val("rst_drain_done", done, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_val("rst_drain_idle_done", done, 0);

    in_row1 = 16'hABCD; in_valid1 = 1'b1;
    check_val("d1_in_ready", in_ready1, 1);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    check_val("d1_out_valid", out_valid1, 1);
    check_val("d1_busy", busy1, 1);
    check_val("d1_in_ready_drain", in_ready1, 0);
    check_val("d1_out_row", out_row1, 16'hABCD);
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    check_val("d1_done", done1, 1);
    check_val("d1_out_valid_idle", out_valid1, 0);
    @(posedge clk); #1;
    check_val("d1_done_clear", done1, 0);

`ifdef MTX_ABORT_EN
    load_matrix(1'b1, 1'b1);
    check_val("abort_beat0", out_row, COLS[0]);
    @(posedge clk); #1;
    check_val("abort_beat1_row", out_row, COLS[1]);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_val("abort_out_valid", out_valid, 0);
    check_val("abort_in_ready", in_ready, 1);
    check_val("abort_busy", busy, 0);
    check_val("abort_no_done", done, 0);
    @(posedge clk); #1;
    check_val("abort_no_done_late", done, 0);
    load_matrix(1'b1, 1'b1);
    drain_matrix(1'b1, -1, "after_abort_beat");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
